// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the ID-stage hazard sequencer.
package structures;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        LSTALL = 1'b1
    } hz_state_t;

    localparam logic [4:0] XZR_IDX = 5'd31;

endpackage

// File: rtl/hazard_controller_perf_counter.sv
// 32-bit saturating event counter with synchronous active-high clear.
module hazard_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] r_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (inc && (r_count != 32'hFFFF_FFFF))
            r_count <= r_count + 32'd1;
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_controller.sv
// Load-use / flag-use stall and taken-branch flush sequencer for the ID stage.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_controller
    import structures::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm,
    input  logic        id_uses_rn,
    input  logic        id_uses_rm,
    input  logic        id_reads_flags,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    input  logic        ex_set_flags,
    input  logic        mem_br_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        bubble_ctrl,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        flush_exmem,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    // The detect cycle is itself a stall, so LSTALL covers the remaining cycles.
    localparam logic [1:0] CNT_LOAD = 2'(LOAD_STALL_CYCLES - 1);

    hz_state_t  r_state, w_state_nxt;
    logic [1:0] r_cnt, w_cnt_nxt;
    logic       w_load_haz, w_flag_haz, w_stall;

    assign w_load_haz = id_valid && ex_mem_read && ex_reg_write && (ex_rd != XZR_IDX) &&
                        ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));
    assign w_flag_haz = id_valid && id_reads_flags && ex_set_flags;
    assign w_stall    = (r_state == LSTALL) || w_load_haz || w_flag_haz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (mem_br_taken) begin
            w_state_nxt = RUN;
            w_cnt_nxt   = 2'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_load_haz && (LOAD_STALL_CYCLES > 1)) begin
                        w_state_nxt = LSTALL;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
                LSTALL: begin
                    w_cnt_nxt = r_cnt - 2'd1;
                    if (r_cnt == 2'd1)
                        w_state_nxt = RUN;
                end
                default: begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        bubble_ctrl = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_exmem = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            bubble_ctrl = 1'b1;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
        end else if (mem_br_taken) begin
            // Branch wins over any stall: load the target and squash the three younger stages.
            bubble_ctrl = 1'b1;
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
        end else if (w_stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            bubble_ctrl = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall && !mem_br_taken),
        .count (stall_cnt)
    );

    hazard_perf_counter u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_br_taken),
        .count (flush_cnt)
    );
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench: two instances (1 and 3 load-stall cycles) share one directed stimulus stream.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_rn, id_uses_rm, id_reads_flags;
    logic [4:0]  id_rn, id_rm, ex_rd;
    logic        ex_mem_read, ex_reg_write, ex_set_flags, mem_br_taken;

    logic        pc1, if1, bb1, fi1, fd1, fe1;
    logic        pc3, if3, bb3, fi3, fd3, fe3;
    logic [31:0] sc1, fc1, sc3, fc3;

    always #5 clk = ~clk;

    hazard_controller #(.LOAD_STALL_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_reads_flags(id_reads_flags),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .ex_set_flags(ex_set_flags), .mem_br_taken(mem_br_taken),
        .pc_write(pc1), .ifid_write(if1), .bubble_ctrl(bb1),
        .flush_ifid(fi1), .flush_idex(fd1), .flush_exmem(fe1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    hazard_controller #(.LOAD_STALL_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_reads_flags(id_reads_flags),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .ex_set_flags(ex_set_flags), .mem_br_taken(mem_br_taken),
        .pc_write(pc3), .ifid_write(if3), .bubble_ctrl(bb3),
        .flush_ifid(fi3), .flush_idex(fd3), .flush_exmem(fe3),
        .stall_cnt(sc3), .flush_cnt(fc3)
    );

    // Output word: {pc_write, ifid_write, bubble_ctrl, flush_ifid, flush_idex, flush_exmem}
    localparam logic [5:0] NRM = 6'b110000;
    localparam logic [5:0] STL = 6'b001000;
    localparam logic [5:0] BRN = 6'b111111;
    localparam logic [5:0] RST = 6'b001111;

    typedef struct {
        string       name;
        logic [5:0]  e1, e3;
        logic [31:0] s1, f1, s3, f3;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input string what, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s %s: got %0h, expected %0h", name, what, act, req);
        end
    endtask

    // Monitor: every cycle the DUTs present a decoded output word; compare against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            chk(e.name, "dut1_out", {26'd0, pc1, if1, bb1, fi1, fd1, fe1}, {26'd0, e.e1});
            chk(e.name, "dut3_out", {26'd0, pc3, if3, bb3, fi3, fd3, fe3}, {26'd0, e.e3});
`ifdef HAZARD_PERF_CNT_EN
            chk(e.name, "dut1_stall_cnt", sc1, e.s1);
            chk(e.name, "dut1_flush_cnt", fc1, e.f1);
            chk(e.name, "dut3_stall_cnt", sc3, e.s3);
            chk(e.name, "dut3_flush_cnt", fc3, e.f3);
`else
            chk(e.name, "dut1_stall_cnt", sc1, 32'd0);
            chk(e.name, "dut1_flush_cnt", fc1, 32'd0);
            chk(e.name, "dut3_stall_cnt", sc3, 32'd0);
            chk(e.name, "dut3_flush_cnt", fc3, 32'd0);
`endif
        end
    end

    task automatic vec(input string name, input logic r, input logic v,
                       input logic [4:0] rn, input logic urn, input logic [4:0] rm, input logic urm,
                       input logic rf, input logic mr, input logic rw, input logic [4:0] rd,
                       input logic sf, input logic br,
                       input logic [5:0] e1, input logic [5:0] e3,
                       input int s1, input int f1, input int s3, input int f3);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_rn = rn; id_uses_rn = urn; id_rm = rm; id_uses_rm = urm;
        id_reads_flags = rf; ex_mem_read = mr; ex_reg_write = rw; ex_rd = rd;
        ex_set_flags = sf; mem_br_taken = br;
        e.name = name; e.e1 = e1; e.e3 = e3;
        e.s1 = 32'(s1); e.f1 = 32'(f1); e.s3 = 32'(s3); e.f3 = 32'(f3);
        exp_q.push_back(e);
    endtask

    task automatic idle(input string name, input logic [5:0] e1, input logic [5:0] e3,
                        input int s1, input int f1, input int s3, input int f3);
        vec(name, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, e1, e3, s1, f1, s3, f3);
    endtask

    initial begin
        rst = 1'b1; id_valid = 0; id_rn = 0; id_rm = 0; id_uses_rn = 0; id_uses_rm = 0;
        id_reads_flags = 0; ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
        ex_set_flags = 0; mem_br_taken = 0;
        repeat (2) @(posedge clk);

        //   name          rst v  rn     urn rm    urm rf mr rw rd     sf br  dut1 dut3 s1 f1 s3 f3
        vec("reset",        1, 0, 5'd0,  0, 5'd0,  0, 0, 0, 0, 5'd0,  0, 0, RST, RST, 0, 0, 0, 0);
        idle("idle0",                                                          NRM, NRM, 0, 0, 0, 0);
        vec("load_rn",      0, 1, 5'd2,  1, 5'd0,  0, 0, 1, 1, 5'd2,  0, 0, STL, STL, 0, 0, 0, 0);
        idle("load_c2",                                                        NRM, STL, 1, 0, 1, 0);
        idle("load_c3",                                                        NRM, STL, 1, 0, 2, 0);
        idle("load_done",                                                      NRM, NRM, 1, 0, 3, 0);
        vec("xzr",          0, 1, 5'd31, 1, 5'd0,  0, 0, 1, 1, 5'd31, 0, 0, NRM, NRM, 1, 0, 3, 0);
        vec("flag",         0, 1, 5'd0,  0, 5'd0,  0, 1, 0, 0, 5'd0,  1, 0, STL, STL, 1, 0, 3, 0);
        idle("flag_after",                                                     NRM, NRM, 2, 0, 4, 0);
        vec("load_rm",      0, 1, 5'd0,  0, 5'd7,  1, 0, 1, 1, 5'd7,  0, 0, STL, STL, 2, 0, 4, 0);
        vec("br_in_lstall", 0, 1, 5'd7,  1, 5'd7,  1, 0, 1, 1, 5'd7,  0, 1, BRN, BRN, 3, 0, 5, 0);
        idle("br_after",                                                       NRM, NRM, 3, 1, 5, 1);
        vec("rn_unused",    0, 1, 5'd2,  0, 5'd0,  0, 0, 1, 1, 5'd2,  0, 0, NRM, NRM, 3, 1, 5, 1);
        vec("no_regwrite",  0, 1, 5'd2,  1, 5'd0,  0, 0, 1, 0, 5'd2,  0, 0, NRM, NRM, 3, 1, 5, 1);
        vec("alu_fwd",      0, 1, 5'd2,  1, 5'd0,  0, 0, 0, 1, 5'd2,  0, 0, NRM, NRM, 3, 1, 5, 1);
        vec("id_invalid",   0, 0, 5'd2,  1, 5'd0,  0, 1, 1, 1, 5'd2,  1, 0, NRM, NRM, 3, 1, 5, 1);
        vec("load_flag",    0, 1, 5'd4,  1, 5'd0,  0, 1, 1, 1, 5'd4,  1, 0, STL, STL, 3, 1, 5, 1);
        vec("lstall_ign",   0, 1, 5'd0,  0, 5'd0,  0, 1, 0, 0, 5'd0,  1, 0, STL, STL, 4, 1, 6, 1);
        vec("rst_mid",      1, 0, 5'd0,  0, 5'd0,  0, 0, 0, 0, 5'd0,  0, 0, RST, RST, 5, 1, 7, 1);
        idle("rst_release",                                                    NRM, NRM, 0, 0, 0, 0);
        idle("run_after",                                                      NRM, NRM, 0, 0, 0, 0);

        begin
            int budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                n_miss++;
                $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencer for the 5-stage ARM datapath. Sits beside `Control` in ID and drives its `bubble_ctrl` input. Detects load-use and flag-use hazards between ID and EX, and freezes PC and IF/ID for the required number of cycles. On a taken branch resolved in MEM, it squashes the three younger pipeline registers.

## Interface
- `LOAD_STALL_CYCLES`, default 1: bubbles inserted per load-use hazard. Legal values: 1 (with forwarding) to 3.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  the IF/ID register holds a real instruction.
- `id_rn`, `id_rm`  in  5 each  source register numbers of the instruction in ID.
- `id_uses_rn`, `id_uses_rm`  in  1 each  the ID instruction reads that source.
- `id_reads_flags`  in  1  the ID instruction is B.LT.
- `ex_mem_read`  in  1  the EX instruction is LDUR.
- `ex_reg_write`  in  1  the EX instruction writes Rd.
- `ex_rd`  in  5  destination register of the EX instruction.
- `ex_set_flags`  in  1  the EX instruction is ADDS/SUBS.
- `mem_br_taken`  in  1  a branch in MEM is resolved taken.
- `pc_write`  out  1  PC update enable.
- `ifid_write`  out  1  IF/ID load enable.
- `bubble_ctrl`  out  1  zero the ID control word into ID/EX.
- `flush_ifid`, `flush_idex`, `flush_exmem`  out  1 each  synchronous clear of that pipeline register.
- `stall_cnt`, `flush_cnt`  out  32 each  performance counters (see Configuration).

## Operation
- States: RUN, LSTALL. A down-counter `cnt` is 2 bits wide.
- `load_haz` is asserted when all of these hold:
  - `id_valid`, `ex_mem_read` and `ex_reg_write` are high;
  - `ex_rd` is not 31;
  - `id_uses_rn` is high with `id_rn` equal to `ex_rd`, or `id_uses_rm` is high with `id_rm` equal to `ex_rd`.
- `flag_haz` is asserted when `id_valid`, `id_reads_flags` and `ex_set_flags` are all high.
- `stall` is asserted in RUN when `load_haz` or `flag_haz` is high. It is always asserted in LSTALL.
  - When `stall` is high, outputs are `pc_write`=0, `ifid_write`=0, `bubble_ctrl`=1.
  - When `stall` is low, outputs are `pc_write`=1, `ifid_write`=1, `bubble_ctrl`=0.
- State transitions:
  - RUN to LSTALL: on `load_haz` with `LOAD_STALL_CYCLES`>1; `cnt` loads `LOAD_STALL_CYCLES`-1.
  - `flag_haz` never leaves RUN; it causes exactly one bubble.
  - LSTALL: `cnt` decrements each cycle. When `cnt`==1, the next state is RUN.
  - In LSTALL, hazard inputs are ignored.
- Taken branch (`mem_br_taken`=1):
  - All three flush outputs are 1 that cycle. `pc_write`=1 so the target loads.
  - `ifid_write`=1 and `bubble_ctrl`=1.
  - Branch has priority over any stall. The next state is RUN and `cnt` is cleared, aborting an LSTALL in progress.
- Reset (`rst`=1): state goes to RUN and `cnt` to 0. While `rst` is high:
  - `pc_write`=0, `ifid_write`=0, `bubble_ctrl`=1, all flushes 1.
  - Counters clear to 0.
- Register 31 (XZR) as `ex_rd` never causes a hazard.

## Timing
- Hazard detection and output decode are combinational from current inputs and state. No added latency.
- A load-use hazard produces exactly `LOAD_STALL_CYCLES` consecutive stall cycles, starting in the detect cycle.
- The flush outputs are single-cycle pulses aligned with `mem_br_taken`. Three instructions are squashed per taken branch.
- Same-cycle `load_haz` and `flag_haz`: treated as a load hazard (`LOAD_STALL_CYCLES` bubbles).
- `rst` asserted during LSTALL takes effect at the next edge. The next cycle is RUN.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt` increments on every cycle with `stall`=1 and `mem_br_taken`=0.
  - `flush_cnt` increments on every cycle with `mem_br_taken`=1.
  - Both are 32-bit and saturate at 32'hFFFF_FFFF. Both clear on `rst`.
- `HAZARD_PERF_CNT_EN` undefined: both ports remain and are tied to 0. No counter flops are built.

## Structure
- Package `structures` gains:
  - enum `hz_state_t` {RUN, LSTALL};
  - constant `XZR_IDX` = 5'd31.
- One sub-module, `hazard_perf_counter`: a single 32-bit saturating counter with `clk`, `rst` and `inc` inputs. It is instantiated twice, only under `HAZARD_PERF_CNT_EN`.

## Test plan
- Load-use: EX = LDUR X2 (`ex_rd`=2, `ex_mem_read`=1); ID = ADDS using `id_rn`=2, `LOAD_STALL_CYCLES`=1. Required: one cycle of `pc_write`=0, `bubble_ctrl`=1, then the next cycle is normal.
- `LOAD_STALL_CYCLES`=3, same stimulus held for one cycle then removed. Required: exactly 3 stall cycles, then RUN; with the macro defined, `stall_cnt`=3.
- XZR: `ex_rd`=31 with matching `id_rn`=31. Required: no stall.
- Flag hazard: `ex_set_flags`=1 and `id_reads_flags`=1. Required: one bubble, and no transition to LSTALL.
- `mem_br_taken`=1 in the second cycle of a 3-cycle LSTALL. Required: all flushes=1 and `pc_write`=1 that cycle; normal operation next cycle; `flush_cnt`=1.
- `rst` asserted mid-LSTALL. Required: `bubble_ctrl`=1 and flushes=1 during reset; RUN with counters at 0 after release.
